// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - RV32I OP/OP-IMM opcode, funct and ALU op constants for the issue stage
package alu_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // op = {imm, alt, 1, funct3}; the register forms are listed, OR in ALU_IMM for OP-IMM
  localparam logic [5:0] ALU_NOP  = 6'b000000;
  localparam logic [5:0] ALU_ADD  = 6'b001000;
  localparam logic [5:0] ALU_SLL  = 6'b001001;
  localparam logic [5:0] ALU_SLT  = 6'b001010;
  localparam logic [5:0] ALU_SLTU = 6'b001011;
  localparam logic [5:0] ALU_XOR  = 6'b001100;
  localparam logic [5:0] ALU_SRL  = 6'b001101;
  localparam logic [5:0] ALU_OR   = 6'b001110;
  localparam logic [5:0] ALU_AND  = 6'b001111;
  localparam logic [5:0] ALU_SUB  = 6'b011000;
  localparam logic [5:0] ALU_SRA  = 6'b011101;
  localparam logic [5:0] ALU_IMM  = 6'b100000;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  rd;
    logic        wb_en;
    logic        illegal;
  } issue_t;

  function automatic logic [5:0] alu_op(input logic is_imm, input logic alt,
                                        input logic [2:0] funct3);
    return {is_imm, alt, 1'b1, funct3};
  endfunction

endpackage

// File: rtl/alu_decode.sv
// rtl/alu_decode.sv - combinational RV32I OP/OP-IMM decoder producing the ALU issue bundle
// Build option: ALU_ISSUE_BYPASS_EN forwards the writeback port onto register operands.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
`ifdef ALU_ISSUE_BYPASS_EN
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
`endif
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output issue_t      dec
);

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic        is_op;
  logic        is_imm;
  logic        is_shift;
  logic        alt;
  logic        legal;
  logic [31:0] src1;
  logic [31:0] src2;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];

  assign is_op    = (opcode == OPC_OP);
  assign is_imm   = (opcode == OPC_OP_IMM);
  assign is_shift = (funct3 == F3_SLL) || (funct3 == F3_SR);

  assign alt = instr[30] &
               ((is_op  && ((funct3 == F3_ADD) || (funct3 == F3_SR))) ||
                (is_imm &&  (funct3 == F3_SR)));

  always_comb begin
    legal = 1'b0;
    if (is_op) begin
      legal = (funct7 == F7_BASE) ||
              ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR)));
    end else if (is_imm) begin
      case (funct3)
        F3_SLL:  legal = (funct7 == F7_BASE);
        F3_SR:   legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
        default: legal = 1'b1;
      endcase
    end
  end

`ifdef ALU_ISSUE_BYPASS_EN
  // x0 never forwards; rs2 forwarding only matters when in2 is register-sourced
  assign src1 = (wb_en && (wb_rd != 5'd0) && (wb_rd == rs1_addr)) ? wb_data : rs1_data;
  assign src2 = (wb_en && (wb_rd != 5'd0) && (wb_rd == rs2_addr)) ? wb_data : rs2_data;
`else
  assign src1 = rs1_data;
  assign src2 = rs2_data;
`endif

  always_comb begin
    dec.op  = legal ? alu_op(is_imm, alt, funct3) : ALU_NOP;
    dec.in1 = src1;
    if (is_imm) begin
      dec.in2 = is_shift ? {27'b0, instr[24:20]} : {{20{instr[31]}}, instr[31:20]};
    end else begin
      dec.in2 = src2;
    end
    dec.rd      = instr[11:7];
    dec.wb_en   = legal && (instr[11:7] != 5'd0);
    dec.illegal = !legal;
  end

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - decode/issue stage: single-entry valid/ready register in front of the ALU
// Build option: ALU_ISSUE_BYPASS_EN adds the wb_en/wb_rd/wb_data forwarding port.
module alu_issue
  import alu_pkg::*;
#(
  parameter int         XLEN   = 32,
  parameter logic [5:0] RST_OP = 6'd0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
`ifdef ALU_ISSUE_BYPASS_EN
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      out_op,
  output logic [XLEN-1:0] out_in1,
  output logic [XLEN-1:0] out_in2,
  output logic [4:0]      out_rd,
  output logic            out_wb_en,
  output logic            out_illegal
);

  issue_t dec;
  logic   accept;

  alu_decode u_decode (
    .instr    (in_instr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
`ifdef ALU_ISSUE_BYPASS_EN
    .wb_en    (wb_en),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
`endif
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .dec      (dec)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Data fields only move on accept, so a pop or flush leaves the last bundle visible
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_op      <= RST_OP;
      out_in1     <= '0;
      out_in2     <= '0;
      out_rd      <= 5'd0;
      out_wb_en   <= 1'b0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_op      <= dec.op;
      out_in1     <= dec.in1;
      out_in2     <= dec.in2;
      out_rd      <= dec.rd;
      out_wb_en   <= dec.wb_en;
      out_illegal <= dec.illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - self-checking bench for alu_issue: directed vectors plus randomized scoreboard
// Build option: ALU_ISSUE_BYPASS_EN enables the writeback forwarding scenario.
module tb_alu_issue;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  rd;
    logic        wb_en;
    logic        illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = 32'd0;
  logic [31:0] rs1_data = 32'd0;
  logic [31:0] rs2_data = 32'd0;
  logic        in_ready;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        out_valid;
  logic [5:0]  out_op;
  logic [31:0] out_in1;
  logic [31:0] out_in2;
  logic [4:0]  out_rd;
  logic        out_wb_en;
  logic        out_illegal;
`ifdef ALU_ISSUE_BYPASS_EN
  logic        wb_en = 1'b0;
  logic [4:0]  wb_rd = 5'd0;
  logic [31:0] wb_data = 32'd0;
`endif

  int checks = 0;
  int failures = 0;

  exp_t got;
  assign got = {out_op, out_in1, out_in2, out_rd, out_wb_en, out_illegal};

  always #5 clk = ~clk;

  alu_issue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
`ifdef ALU_ISSUE_BYPASS_EN
    .wb_en       (wb_en),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_op      (out_op),
    .out_in1     (out_in1),
    .out_in2     (out_in2),
    .out_rd      (out_rd),
    .out_wb_en   (out_wb_en),
    .out_illegal (out_illegal)
  );

  // Reference decode built from the instruction-set rules, not from the RTL structure
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] a,
                                      input logic [31:0] b, input logic we,
                                      input logic [4:0] wr, input logic [31:0] wd);
    exp_t       e;
    logic [2:0] f3;
    logic [6:0] f7;
    bit         is_reg, is_imm, legal, alt;
    f3     = ins[14:12];
    f7     = ins[31:25];
    is_reg = (ins[6:0] == 7'h33);
    is_imm = (ins[6:0] == 7'h13);
    if (is_reg)      legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    else if (is_imm) legal = (f3 == 3'd1) ? (f7 == 7'h00) :
                             (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
    else             legal = 1'b0;
    alt = ins[30] && ((is_reg && (f3 == 3'd0 || f3 == 3'd5)) || (is_imm && f3 == 3'd5));
    e.op = legal ? 6'((is_imm ? 32 : 0) + (alt ? 16 : 0) + 8 + int'(f3)) : 6'd0;
    e.in1 = (we && wr != 0 && wr == ins[19:15]) ? wd : a;
    if (is_imm)
      e.in2 = (f3 == 3'd1 || f3 == 3'd5) ? 32'(ins[24:20]) : 32'($signed(ins[31:20]));
    else
      e.in2 = (we && wr != 0 && wr == ins[24:20]) ? wd : b;
    e.rd      = ins[11:7];
    e.wb_en   = legal && (ins[11:7] != 0);
    e.illegal = !legal;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom % 8)
      0, 1, 2: w[6:0] = 7'h33;
      3, 4, 5: w[6:0] = 7'h13;
      6:       w[6:0] = 7'h03;
      default: ;
    endcase
    case ($urandom % 4)
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b, input logic ordy);
    in_valid  = v;
    in_instr  = ins;
    rs1_data  = a;
    rs2_data  = b;
    out_ready = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    step();
    step();
    checks++;
    if (out_valid !== 1'b0 || got !== exp_t'(0)) begin
      failures++;
      $display("FAIL reset_state: got valid=%b bundle=%h expected valid=0 bundle=0", out_valid, got);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_decode_vectors();
    exp_t e;
    drive(1'b1, 32'h002081B3, 32'd5, 32'd7, 1'b1);
    #1;
    checks++;
    if (rs1_addr !== 5'd1 || rs2_addr !== 5'd2) begin
      failures++;
      $display("FAIL rs_addr: got %0d/%0d expected 1/2", rs1_addr, rs2_addr);
    end
    step();
    e = exp_t'{6'b001000, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0};
    checks++;
    if (out_valid !== 1'b1 || got !== e) begin
      failures++;
      $display("FAIL add: got valid=%b %h expected valid=1 %h", out_valid, got, e);
    end
    drive(1'b1, 32'h402081B3, 32'd9, 32'd4, 1'b1);
    step();
    e = exp_t'{6'b011000, 32'd9, 32'd4, 5'd3, 1'b1, 1'b0};
    checks++;
    if (out_valid !== 1'b1 || got !== e) begin
      failures++;
      $display("FAIL sub: got valid=%b %h expected valid=1 %h", out_valid, got, e);
    end
    drive(1'b1, 32'hFFF00093, 32'd0, 32'h1111, 1'b1);
    step();
    e = exp_t'{6'b101000, 32'd0, 32'hFFFFFFFF, 5'd1, 1'b1, 1'b0};
    checks++;
    if (out_valid !== 1'b1 || got !== e) begin
      failures++;
      $display("FAIL addi: got valid=%b %h expected valid=1 %h", out_valid, got, e);
    end
    drive(1'b1, 32'h40335293, 32'h80000000, 32'h2222, 1'b1);
    step();
    e = exp_t'{6'b111101, 32'h80000000, 32'd3, 5'd5, 1'b1, 1'b0};
    checks++;
    if (out_valid !== 1'b1 || got !== e) begin
      failures++;
      $display("FAIL srai: got valid=%b %h expected valid=1 %h", out_valid, got, e);
    end
    drive(1'b1, 32'h00000003, 32'h55, 32'h1234, 1'b1);
    step();
    e = exp_t'{6'b000000, 32'h55, 32'h1234, 5'd0, 1'b0, 1'b1};
    checks++;
    if (out_valid !== 1'b1 || got !== e) begin
      failures++;
      $display("FAIL illegal_opcode: got valid=%b %h expected valid=1 %h", out_valid, got, e);
    end
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    step();
    checks++;
    if (out_valid !== 1'b0 || got !== e) begin
      failures++;
      $display("FAIL pop_hold_data: got valid=%b %h expected valid=0 %h", out_valid, got, e);
    end
  endtask

  task automatic test_hold();
    exp_t e_add, e_sub;
    e_add = exp_t'{6'b001000, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0};
    e_sub = exp_t'{6'b011000, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0};
    drive(1'b1, 32'h002081B3, 32'd5, 32'd7, 1'b1);
    step();
    drive(1'b1, 32'h402081B3, 32'd5, 32'd7, 1'b0);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL hold_in_ready: got %b expected 0", in_ready);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || got !== e_add || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_stable%0d: got valid=%b rdy=%b %h expected valid=1 rdy=0 %h",
                 i, out_valid, in_ready, got, e_add);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL release_in_ready: got %b expected 1", in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || got !== e_sub) begin
      failures++;
      $display("FAIL back_to_back: got valid=%b %h expected valid=1 %h", out_valid, got, e_sub);
    end
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    step();
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h002081B3, 32'd5, 32'd7, 1'b1);
    step();
    drive(1'b1, 32'h402081B3, 32'd1, 32'd2, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_valid: got %b expected 0", out_valid);
    end
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_dropped: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h002081B3, 32'd5, 32'd7, 1'b0);
    step();
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || got !== exp_t'(0)) begin
      failures++;
      $display("FAIL async_reset: got valid=%b %h expected valid=0 0", out_valid, got);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_valid: got %b expected 0", out_valid);
    end
  endtask

`ifdef ALU_ISSUE_BYPASS_EN
  task automatic test_bypass();
    exp_t e;
    wb_en = 1'b1;
    wb_rd = 5'd1;
    wb_data = 32'hAA;
    drive(1'b1, 32'h002081B3, 32'd5, 32'd7, 1'b1);
    step();
    e = exp_t'{6'b001000, 32'hAA, 32'd7, 5'd3, 1'b1, 1'b0};
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL bypass_rs1: got %h expected %h", got, e);
    end
    wb_rd = 5'd0;
    drive(1'b1, 32'h002001B3, 32'd0, 32'd7, 1'b1);
    step();
    e = exp_t'{6'b001000, 32'd0, 32'd7, 5'd3, 1'b1, 1'b0};
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL bypass_x0: got %h expected %h", got, e);
    end
    wb_en = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    step();
  endtask
`endif

  task automatic test_random();
    exp_t mdl;
    bit   mdl_valid;
    logic we;
    logic [4:0] wr;
    logic [31:0] wd;
    rst_n = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    #1;
    rst_n = 1'b1;
    step();
    mdl = '0;
    mdl_valid = 1'b0;
    for (int i = 0; i < 600; i++) begin
      drive($urandom % 4 != 0, rand_instr(), $urandom, $urandom, $urandom % 3 != 0);
      flush = ($urandom % 10 == 0);
      we = 1'b0;
      wr = 5'd0;
      wd = 32'd0;
`ifdef ALU_ISSUE_BYPASS_EN
      wb_en = $urandom % 2 == 0;
      case ($urandom % 3)
        0: wb_rd = in_instr[19:15];
        1: wb_rd = in_instr[24:20];
        default: wb_rd = 5'($urandom);
      endcase
      wb_data = $urandom;
      we = wb_en;
      wr = wb_rd;
      wd = wb_data;
`endif
      #1;
      checks++;
      if (in_ready !== (!mdl_valid || out_ready) ||
          rs1_addr !== in_instr[19:15] || rs2_addr !== in_instr[24:20]) begin
        failures++;
        $display("FAIL rand_comb[%0d]: got rdy=%b rs=%0d/%0d expected rdy=%b rs=%0d/%0d", i,
                 in_ready, rs1_addr, rs2_addr, !mdl_valid || out_ready,
                 in_instr[19:15], in_instr[24:20]);
      end
      if (flush) mdl_valid = 1'b0;
      else if (in_valid && (!mdl_valid || out_ready)) begin
        mdl_valid = 1'b1;
        mdl = ref_decode(in_instr, rs1_data, rs2_data, we, wr, wd);
      end else if (out_ready) mdl_valid = 1'b0;
      step();
      checks++;
      if (out_valid !== mdl_valid || got !== mdl) begin
        failures++;
        $display("FAIL rand_out[%0d]: got valid=%b %h expected valid=%b %h", i,
                 out_valid, got, mdl_valid, mdl);
      end
    end
    flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    step();
  endtask

  initial begin
    test_reset();
    test_decode_vectors();
    test_hold();
    test_flush();
    test_async_reset();
`ifdef ALU_ISSUE_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
